// File: rtl/chnnl_trig_unit.sv
// ---------------------------------------------------------------------------
// chnnl_trig_unit
// Channel trigger stage for the logic analyser digital path. Checks each
// channel against its trigger config, qualifies the result with prot_trig and
// armed, runs the trigger state machine and counts post-trigger samples.
//
// Build option:
//   CHTRIG_SYNC_EN  when defined, chL/chH pass through a 2-flop synchronizer.
//                   When undefined, chL/chH are used as clk-synchronous inputs.
// ---------------------------------------------------------------------------
module chnnl_trig_unit #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned CFG_W  = 5,
    parameter int unsigned POS_W  = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         chL,
    input  logic [NUM_CH-1:0]         chH,
    input  logic [NUM_CH*CFG_W-1:0]   ch_cfg,
    input  logic                      prot_trig,
    input  logic                      armed,
    input  logic                      smpl_en,
    input  logic [POS_W-1:0]          trig_pos,
    input  logic                      clr_cap_done,
    output logic [NUM_CH-1:0]         ch_trig,
    output logic                      triggered,
    output logic                      capture_done,
    output logic [POS_W-1:0]          post_cnt
);

    localparam int unsigned CNT_XW = POS_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIGD = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] l_s;
    logic [NUM_CH-1:0] h_s;

`ifdef CHTRIG_SYNC_EN
    logic [NUM_CH-1:0] l_meta_q, l_meta_d;
    logic [NUM_CH-1:0] h_meta_q, h_meta_d;
    logic [NUM_CH-1:0] l_sync_q, l_sync_d;
    logic [NUM_CH-1:0] h_sync_q, h_sync_d;

    // Two-stage synchronizer next values
    always_comb begin
        l_meta_d = chL;
        h_meta_d = chH;
        l_sync_d = l_meta_q;
        h_sync_d = h_meta_q;
    end

    // Synchronizer flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_meta_q <= '0;
            h_meta_q <= '0;
            l_sync_q <= '0;
            h_sync_q <= '0;
        end else begin
            l_meta_q <= l_meta_d;
            h_meta_q <= h_meta_d;
            l_sync_q <= l_sync_d;
            h_sync_q <= h_sync_d;
        end
    end

    assign l_s = l_sync_q;
    assign h_s = h_sync_q;
`else
    assign l_s = chL;
    assign h_s = chH;
`endif

    // -----------------------------------------------------------------------
    // Edge detection and sticky edge flags
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] l_prev_q, l_prev_d;
    logic [NUM_CH-1:0] h_prev_q, h_prev_d;
    logic [NUM_CH-1:0] neg_flag_q, neg_flag_d;
    logic [NUM_CH-1:0] pos_flag_q, pos_flag_d;
    logic [NUM_CH-1:0] l_fall_c;
    logic [NUM_CH-1:0] h_rise_c;

    // Edge flags are sticky while armed; a new edge beats the disarm clear
    always_comb begin
        l_prev_d   = l_s;
        h_prev_d   = h_s;
        l_fall_c   = l_prev_q & ~l_s;
        h_rise_c   = ~h_prev_q & h_s;
        neg_flag_d = l_fall_c | (neg_flag_q & {NUM_CH{armed}});
        pos_flag_d = h_rise_c | (pos_flag_q & {NUM_CH{armed}});
    end

    // Previous-value and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_prev_q   <= '0;
            h_prev_q   <= '0;
            neg_flag_q <= '0;
            pos_flag_q <= '0;
        end else begin
            l_prev_q   <= l_prev_d;
            h_prev_q   <= h_prev_d;
            neg_flag_q <= neg_flag_d;
            pos_flag_q <= pos_flag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel trigger condition
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] ch_trig_q, ch_trig_d;

    // Any enabled condition bit satisfies the channel; an all-zero cfg blocks it
    always_comb begin
        ch_trig_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_trig_d[i] = |(ch_cfg[i*CFG_W +: CFG_W] &
                             CFG_W'({pos_flag_q[i], neg_flag_q[i], h_s[i], ~l_s[i], 1'b1}));
        end
    end

    // Channel trigger register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_trig_q <= '0;
        end else begin
            ch_trig_q <= ch_trig_d;
        end
    end

    // -----------------------------------------------------------------------
    // Trigger state machine and post-trigger counter
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              triggered_q, triggered_d;
    logic              capture_done_q, capture_done_d;
    logic [POS_W-1:0]  post_cnt_q, post_cnt_d;
    logic              trig_set_c;
    logic              last_smpl_c;
    logic              below_pos_c;

    assign trig_set_c  = (&ch_trig_q) & prot_trig & armed;
    // This sample brings the count up to trig_pos (>= keeps it from running on)
    assign last_smpl_c = (CNT_XW'(post_cnt_q) + CNT_XW'(1)) >= CNT_XW'(trig_pos);
    assign below_pos_c = post_cnt_q < trig_pos;

    // Next state, trigger flags and saturating post-trigger count
    always_comb begin
        state_d        = state_q;
        triggered_d    = triggered_q;
        capture_done_d = capture_done_q;
        post_cnt_d     = post_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_cap_done) begin
                    post_cnt_d = '0;
                end
                if (armed) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (clr_cap_done) begin
                    post_cnt_d = '0;
                    if (!armed) begin
                        state_d = ST_IDLE;
                    end
                end else if (trig_set_c) begin
                    state_d     = ST_TRIGD;
                    triggered_d = 1'b1;
                end else if (!armed) begin
                    state_d = ST_IDLE;
                end
            end

            ST_TRIGD: begin
                if (clr_cap_done) begin
                    state_d        = ST_IDLE;
                    triggered_d    = 1'b0;
                    capture_done_d = 1'b0;
                    post_cnt_d     = '0;
                end else if (trig_pos == '0) begin
                    state_d        = ST_DONE;
                    capture_done_d = 1'b1;
                end else if (smpl_en) begin
                    if (below_pos_c) begin
                        post_cnt_d = POS_W'(post_cnt_q + POS_W'(1));
                    end
                    if (last_smpl_c) begin
                        state_d        = ST_DONE;
                        capture_done_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (clr_cap_done) begin
                    state_d        = ST_IDLE;
                    triggered_d    = 1'b0;
                    capture_done_d = 1'b0;
                    post_cnt_d     = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            triggered_q    <= 1'b0;
            capture_done_q <= 1'b0;
            post_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            triggered_q    <= triggered_d;
            capture_done_q <= capture_done_d;
            post_cnt_q     <= post_cnt_d;
        end
    end

    assign ch_trig      = ch_trig_q;
    assign triggered    = triggered_q;
    assign capture_done = capture_done_q;
    assign post_cnt     = post_cnt_q;

endmodule
